// File: rtl/shared_memory_mp_if.sv
// Request/response bundle between the per-lane load/store units and shared_memory_mp.
// rsp_err exists only when SHMEM_BOUNDS_CHECK_EN is defined.
interface shared_memory_mp_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W   = DATA_W / 8;

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*32-1:0]     req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS*BE_W-1:0]   req_be;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic [PORT_W-1:0]           rsp_port;
`ifdef SHMEM_BOUNDS_CHECK_EN
    logic                        rsp_err;
`endif

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_port
`ifdef SHMEM_BOUNDS_CHECK_EN
        , input rsp_err
`endif
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_port
`ifdef SHMEM_BOUNDS_CHECK_EN
        , output rsp_err
`endif
    );
endinterface

// File: rtl/shared_memory_mp.sv
// NUM_PORTS requesters share one single-ported RAM via a round-robin arbiter; 1-cycle registered response.
// Optional SHMEM_BOUNDS_CHECK_EN: out-of-range addresses are accepted, never written, and flagged on rsp_err.
module shared_memory_mp #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256
) (
    input  logic             clk,
    input  logic             rst,
    shared_memory_mp_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W   = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PORT_W-1:0]    ptr_q;
    logic [PORT_W:0]      cand_sum;
    logic [PORT_W-1:0]    cand;
    logic [NUM_PORTS-1:0] gnt_p0;
    logic [PORT_W-1:0]    idx_p0;
    logic                 xfer_p0;
    logic                 we_p0;
    logic [31:0]          addr_p0;
    logic [ADDR_W-1:0]    word_p0;
    logic [DATA_W-1:0]    wdata_p0;
    logic [BE_W-1:0]      be_p0;
    logic                 oob_p0;

    logic [NUM_PORTS-1:0] vld_p1;
    logic [DATA_W-1:0]    rdata_p1;
    logic [PORT_W-1:0]    port_p1;

    // ---- stage p0: round-robin grant, searching upward from ptr_q with wrap
    always_comb begin
        gnt_p0   = '0;
        idx_p0   = '0;
        xfer_p0  = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_sum = {1'b0, ptr_q} + (PORT_W+1)'(k);
            if (cand_sum >= (PORT_W+1)'(NUM_PORTS))
                cand_sum = cand_sum - (PORT_W+1)'(NUM_PORTS);
            cand = cand_sum[PORT_W-1:0];
            if (!xfer_p0 && bus.req_valid[cand]) begin
                xfer_p0 = 1'b1;
                idx_p0  = cand;
            end
        end
        if (xfer_p0)
            gnt_p0[idx_p0] = 1'b1;
    end

    assign bus.req_ready = gnt_p0;

    // gnt_p0 is one-hot or zero, so an AND-OR mux picks the winner's fields
    always_comb begin
        we_p0    = 1'b0;
        addr_p0  = '0;
        wdata_p0 = '0;
        be_p0    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_p0[p]) begin
                we_p0    = bus.req_we[p];
                addr_p0  = bus.req_addr[p*32 +: 32];
                wdata_p0 = bus.req_wdata[p*DATA_W +: DATA_W];
                be_p0    = bus.req_be[p*BE_W +: BE_W];
            end
        end
    end

    assign word_p0 = addr_p0[ADDR_W-1:0];

`ifdef SHMEM_BOUNDS_CHECK_EN
    assign oob_p0 = |addr_p0[31:ADDR_W];
`else
    // Upper address bits alias modulo DEPTH and are intentionally dropped.
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr_p0[31:ADDR_W];
    assign oob_p0 = 1'b0;
`endif

    // Write lands at the end of the transfer cycle, so a read granted next cycle sees it.
    always_ff @(posedge clk) begin
        if (xfer_p0 && we_p0 && !oob_p0) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_p0[b])
                    mem[word_p0][8*b +: 8] <= wdata_p0[8*b +: 8];
            end
        end
    end

    // ---- stage p1: registered response, old word captured before the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            vld_p1   <= '0;
            rdata_p1 <= '0;
            port_p1  <= '0;
        end else begin
            vld_p1 <= gnt_p0;
            if (xfer_p0) begin
                ptr_q    <= (idx_p0 == PORT_W'(NUM_PORTS-1)) ? '0 : idx_p0 + 1'b1;
                port_p1  <= idx_p0;
                rdata_p1 <= oob_p0 ? '0 : mem[word_p0];
            end
        end
    end

`ifdef SHMEM_BOUNDS_CHECK_EN
    logic err_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_p1 <= 1'b0;
        else if (xfer_p0)
            err_p1 <= oob_p0;
    end

    assign bus.rsp_err = err_p1;
`endif

    assign bus.rsp_valid = vld_p1;
    assign bus.rsp_rdata = rdata_p1;
    assign bus.rsp_port  = port_p1;

endmodule

// File: tb/tb_shared_memory_mp.sv
// Randomised scoreboard bench for shared_memory_mp: per-port request queues feed a driver,
// a reference model predicts grants and responses, a monitor compares them against the DUT.
module tb_shared_memory_mp;
    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 256;
    localparam int BE_W      = DATA_W / 8;

    typedef struct packed {
        logic              we;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    typedef struct packed {
        int                port;
        logic [DATA_W-1:0] rdata;
        bit                known;
        bit                err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shared_memory_mp_if #(.NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W)) bus ();

    shared_memory_mp #(.NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    req_t              port_q [NUM_PORTS][$];
    exp_t              exp_q[$];
    int                grant_log[$];
    logic [DATA_W-1:0] mmem [DEPTH];
    bit                known [DEPTH];
    logic [DATA_W-1:0] last_rdata [NUM_PORTS];
    int                present_rate = 100;
    bit [NUM_PORTS-1:0] presenting;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [31:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
        return r;
    endfunction

    function automatic bit all_idle();
        bit idle = (presenting == '0) && (exp_q.size() == 0);
        for (int p = 0; p < NUM_PORTS; p++)
            if (port_q[p].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic wait_drain(input int limit);
        bit done = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            @(posedge clk); #2;
            done = all_idle();
        end
        check("drain_done", {63'd0, done}, 64'd1);
    endtask

    // Requester side: a port holds its head request until it is granted.
    initial begin : driver
        bit [NUM_PORTS-1:0] fired;
        req_t r;
        presenting    = '0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        forever begin
            @(negedge clk);
            fired = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (fired[p] && port_q[p].size() > 0) begin
                    void'(port_q[p].pop_front());
                    presenting[p] = 1'b0;
                end
                if (!presenting[p] && port_q[p].size() > 0 && !rst &&
                    $urandom_range(0, 99) < present_rate)
                    presenting[p] = 1'b1;
                if (presenting[p]) begin
                    r = port_q[p][0];
                    bus.req_valid[p]               = 1'b1;
                    bus.req_we[p]                  = r.we;
                    bus.req_addr[p*32 +: 32]       = r.addr;
                    bus.req_wdata[p*DATA_W +: DATA_W] = r.wdata;
                    bus.req_be[p*BE_W +: BE_W]     = r.be;
                end else begin
                    bus.req_valid[p]               = 1'b0;
                    bus.req_we[p]                  = 1'($urandom);
                    bus.req_addr[p*32 +: 32]       = $urandom;
                    bus.req_wdata[p*DATA_W +: DATA_W] = $urandom;
                    bus.req_be[p*BE_W +: BE_W]     = BE_W'($urandom);
                end
            end
        end
    end

    // Reference model + response checker, evaluated mid-cycle.
    initial begin : monitor
        int   mptr;
        int   waits [NUM_PORTS];
        int   g, c, a;
        bit   found, oob;
        exp_t e;
        logic              we;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        mptr = 0;
        foreach (waits[i]) waits[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mptr = 0;
                foreach (waits[i]) waits[i] = 0;
                continue;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_valid", 64'(bus.rsp_valid), 64'(1 << e.port));
                check("rsp_port", 64'(bus.rsp_port), 64'(e.port));
                if (e.known) check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
`ifdef SHMEM_BOUNDS_CHECK_EN
                check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
`endif
                last_rdata[e.port] = bus.rsp_rdata;
            end else begin
                check("rsp_idle", 64'(bus.rsp_valid), 64'd0);
            end

            found = 1'b0;
            g = 0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                c = (mptr + k) % NUM_PORTS;
                if (!found && bus.req_valid[c]) begin
                    found = 1'b1;
                    g = c;
                end
            end
            check("req_ready", 64'(bus.req_ready), found ? 64'(1 << g) : 64'd0);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (found && p == g) begin
                    check("max_wait", 64'(waits[p] <= NUM_PORTS - 1), 64'd1);
                    waits[p] = 0;
                end else if (bus.req_valid[p]) begin
                    waits[p]++;
                end
            end

            if (found) begin
                we    = bus.req_we[g];
                addr  = bus.req_addr[g*32 +: 32];
                wdata = bus.req_wdata[g*DATA_W +: DATA_W];
                be    = bus.req_be[g*BE_W +: BE_W];
                e.port = g;
                e.err  = 1'b0;
                oob    = 1'b0;
`ifdef SHMEM_BOUNDS_CHECK_EN
                oob = (addr >= DEPTH);
`endif
                if (oob) begin
                    e.rdata = '0;
                    e.known = 1'b1;
                    e.err   = 1'b1;
                end else begin
                    a = int'(addr % DEPTH);
                    e.rdata = mmem[a];
                    e.known = known[a];
                    if (we) begin
                        for (int b = 0; b < BE_W; b++)
                            if (be[b]) mmem[a][8*b +: 8] = wdata[8*b +: 8];
                        if (be == '1) known[a] = 1'b1;
                    end
                end
                exp_q.push_back(e);
                grant_log.push_back(g);
                mptr = (g + 1) % NUM_PORTS;
            end
        end
    end

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : main
        int   start;
        bit   seen;
        req_t r;
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("reset_port", 64'(bus.rsp_port), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);

        for (int a = 0; a < DEPTH; a++)
            port_q[a % NUM_PORTS].push_back(mk(1'b1, 32'(a), $urandom, '1));
        wait_drain(3000);

        port_q[2].push_back(mk(1'b1, 32'd5, 32'hDEADBEEF, 4'hF));
        port_q[2].push_back(mk(1'b0, 32'd5, 32'h0, 4'h0));
        wait_drain(100);
        check("single_rd", 64'(last_rdata[2]), 64'hDEADBEEF);

        port_q[1].push_back(mk(1'b1, 32'd7, 32'h11223344, 4'hF));
        port_q[1].push_back(mk(1'b1, 32'd7, 32'hAABBCCDD, 4'b0101));
        port_q[1].push_back(mk(1'b0, 32'd7, 32'h0, 4'h0));
        wait_drain(100);
        check("byte_en", 64'(last_rdata[1]), 64'h11BB33DD);

        // Async reset while a read response is on the bus: it must vanish at once.
        port_q[1].push_back(mk(1'b0, 32'd7, 32'h0, 4'h0));
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk); #2;
            seen = (bus.rsp_valid != '0);
        end
        check("pre_reset_rsp", 64'(bus.rsp_valid), 64'h2);
        rst = 1'b1;
        #1;
        check("async_valid", 64'(bus.rsp_valid), 64'd0);
        check("async_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("async_port", 64'(bus.rsp_port), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);

        start = grant_log.size();
        for (int p = 0; p < NUM_PORTS; p++)
            for (int j = 0; j < 2; j++)
                port_q[p].push_back(mk(1'b0, 32'($urandom_range(0, DEPTH-1)), 32'h0, 4'h0));
        wait_drain(100);
        for (int i = 0; i < 2*NUM_PORTS; i++)
            check("rr_order", 64'((grant_log.size() > start + i) ? grant_log[start + i] : -1),
                  64'(i % NUM_PORTS));

        port_q[0].push_back(mk(1'b1, 32'd9, 32'h5, 4'hF));
        port_q[1].push_back(mk(1'b0, 32'd9, 32'h0, 4'h0));
        wait_drain(100);
        check("raw_b2b", 64'(last_rdata[1]), 64'h5);

        port_q[3].push_back(mk(1'b1, 32'd0, 32'h01020304, 4'hF));
        port_q[3].push_back(mk(1'b1, 32'd256, 32'hCAFEF00D, 4'hF));
        port_q[3].push_back(mk(1'b0, 32'd0, 32'h0, 4'h0));
        wait_drain(100);
`ifdef SHMEM_BOUNDS_CHECK_EN
        check("bounds_mem0", 64'(last_rdata[3]), 64'h01020304);
`else
        check("alias_mem0", 64'(last_rdata[3]), 64'hCAFEF00D);
`endif

        present_rate = 60;
        for (int n = 0; n < 600; n++) begin
            r.we    = 1'($urandom_range(0, 1));
            r.addr  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH-1));
            r.wdata = $urandom;
            r.be    = BE_W'($urandom_range(0, (1 << BE_W) - 1));
            port_q[$urandom_range(0, NUM_PORTS-1)].push_back(r);
        end
        wait_drain(20000);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
